// File: rtl/fpu_pkg.sv
// Shared FPU definitions: IEEE-754 binary32 exponent constants, integer
// limits, and the pipeline record types used by the ftoi converter.
package fpu_pkg;

  // binary32 exponent landmarks (biased)
  localparam logic [7:0] EXP_BIAS  = 8'd127;
  // Exponent at which the 24-bit mantissa already sits at integer weight 2^0
  localparam logic [7:0] EXP_ALIGN = EXP_BIAS + 8'd23;
  // |x| >= 2^31 from here up, including inf/NaN
  localparam logic [7:0] EXP_OVF   = 8'd158;
  // Smallest exponent whose value (>= 0.5) can round to a nonzero integer
  localparam logic [7:0] EXP_HALF  = 8'd126;
  localparam logic [7:0] EXP_MAX   = 8'd255;

  localparam logic [31:0] INT_MAX = 32'h7FFF_FFFF;
  localparam logic [31:0] INT_MIN = 32'h8000_0000;

  // Operand class decided in the unpack stage
  typedef enum logic [1:0] {
    CLS_ZERO,
    CLS_NAN,
    CLS_SAT,
    CLS_NORM
  } ftoi_cls_e;

  // Per-stage record after alignment
  typedef struct packed {
    logic        sign;
    ftoi_cls_e   cls;
    logic [31:0] mag;
    logic        guard;
    logic        sticky;
  } ftoi_stage_t;

endpackage

// File: rtl/ftoi_align.sv
// Combinational aligner: shifts the 24-bit mantissa to integer weight and
// reports the first dropped bit (guard) and the OR of the rest (sticky).
module ftoi_align (
  input  logic [23:0] mant,
  input  logic        shift_left,
  input  logic [4:0]  shift_amt,
  output logic [31:0] mag,
  output logic        guard,
  output logic        sticky
);

  // Upper 32 bits hold the integer part, lower 32 bits catch every bit a
  // right shift of up to 24 can push out, so nothing is lost.
  logic [63:0] wide;

  // Shift left for large exponents (exact) or right for fractional ones
  always_comb begin
    wide = {8'b0, mant, 32'b0};
    if (shift_left) begin
      wide = wide << shift_amt;
    end else begin
      wide = wide >> shift_amt;
    end
  end

  assign mag    = wide[63:32];
  assign guard  = wide[31];
  assign sticky = |wide[30:0];

endmodule

// File: rtl/ftoi.sv
// Three-stage pipelined binary32 -> signed int32 converter.
// Stage 1 unpacks and classifies, stage 2 aligns, stage 3 rounds, applies
// the sign and saturates. out_valid is input_valid delayed by 3 cycles.
module ftoi #(
  parameter int ROUND_NEAREST = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] in_f,
  input  logic        input_valid,
  output logic [31:0] out_i,
  output logic        out_valid
);

  import fpu_pkg::*;

  // ---------------- stage 1 state ----------------
  logic        s1_valid_q, s1_valid_d;
  logic        s1_sign_q, s1_sign_d;
  ftoi_cls_e   s1_cls_q, s1_cls_d;
  logic [23:0] s1_mant_q, s1_mant_d;
  logic        s1_left_q, s1_left_d;
  logic [4:0]  s1_amt_q, s1_amt_d;

  // ---------------- stage 2 state ----------------
  logic        s2_valid_q, s2_valid_d;
  ftoi_stage_t s2_q, s2_d;

  // ---------------- stage 3 state ----------------
  logic        out_valid_q, out_valid_d;
  logic [31:0] out_i_q, out_i_d;

  // Aligner outputs
  logic [31:0] al_mag;
  logic        al_guard;
  logic        al_sticky;

  // Stage 3 rounding intermediates
  logic        round_inc;
  logic [32:0] rounded;
  logic [31:0] result;

  logic [7:0]  in_exp;
  assign in_exp = in_f[30:23];

  // Stage 1: unpack, classify and derive shift direction/amount
  always_comb begin
    s1_valid_d = input_valid;
    s1_sign_d  = s1_sign_q;
    s1_cls_d   = s1_cls_q;
    s1_mant_d  = s1_mant_q;
    s1_left_d  = s1_left_q;
    s1_amt_d   = s1_amt_q;
    if (input_valid) begin
      s1_sign_d = in_f[31];
      s1_mant_d = {1'b1, in_f[22:0]};
      s1_left_d = (in_exp >= EXP_ALIGN);
      // Only the low 5 bits of (e - 150) matter: NORM shifts are <= 24
      s1_amt_d  = s1_left_d ? (in_exp[4:0] - EXP_ALIGN[4:0])
                            : (EXP_ALIGN[4:0] - in_exp[4:0]);
      if (in_exp == 8'd0) begin
        s1_cls_d = CLS_ZERO;
      end else if (in_exp == EXP_MAX && in_f[22:0] != 23'd0) begin
        s1_cls_d = CLS_NAN;
      end else if (in_exp >= EXP_OVF) begin
        s1_cls_d = CLS_SAT;
      end else if (in_exp < EXP_HALF) begin
        s1_cls_d = CLS_ZERO;
      end else begin
        s1_cls_d = CLS_NORM;
      end
    end
  end

  // Stage 1 registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_sign_q  <= 1'b0;
      s1_cls_q   <= CLS_ZERO;
      s1_mant_q  <= '0;
      s1_left_q  <= 1'b0;
      s1_amt_q   <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_sign_q  <= s1_sign_d;
      s1_cls_q   <= s1_cls_d;
      s1_mant_q  <= s1_mant_d;
      s1_left_q  <= s1_left_d;
      s1_amt_q   <= s1_amt_d;
    end
  end

  ftoi_align u_align (
    .mant       (s1_mant_q),
    .shift_left (s1_left_q),
    .shift_amt  (s1_amt_q),
    .mag        (al_mag),
    .guard      (al_guard),
    .sticky     (al_sticky)
  );

  // Stage 2: capture aligned magnitude with guard/sticky
  always_comb begin
    s2_valid_d  = s1_valid_q;
    s2_d.sign   = s1_sign_q;
    s2_d.cls    = s1_cls_q;
    s2_d.mag    = al_mag;
    s2_d.guard  = al_guard;
    s2_d.sticky = al_sticky;
  end

  // Stage 2 registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid_q <= 1'b0;
      s2_q       <= '0;
    end else begin
      s2_valid_q <= s2_valid_d;
      s2_q       <= s2_d;
    end
  end

  // Stage 3: round, saturate, apply sign; specials bypass rounding
  always_comb begin
    round_inc = (ROUND_NEAREST != 0) && s2_q.guard && (s2_q.sticky || s2_q.mag[0]);
    rounded   = {1'b0, s2_q.mag} + {32'b0, round_inc};
    result    = 32'd0;
    case (s2_q.cls)
      CLS_ZERO: result = 32'd0;
      CLS_NAN:  result = INT_MIN;
      CLS_SAT:  result = s2_q.sign ? INT_MIN : INT_MAX;
      default: begin
        if (rounded[32:31] != 2'b00) begin
          result = s2_q.sign ? INT_MIN : INT_MAX;
        end else if (s2_q.sign && rounded[31:0] != 32'd0) begin
          result = -rounded[31:0];
        end else begin
          result = rounded[31:0];
        end
      end
    endcase
    out_valid_d = s2_valid_q;
    out_i_d     = s2_valid_q ? result : out_i_q;
  end

  // Output registers; out_i holds its last value between results
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_i_q     <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_i_q     <= out_i_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_i     = out_i_q;

endmodule

// File: tb/tb_ftoi.sv
// Bench for ftoi: one nearest-even and one truncating instance share the
// stimulus; a negedge monitor pops expected results from a queue.
module tb_ftoi;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] in_f;
  logic        input_valid;
  logic [31:0] out_i_rne, out_i_trz;
  logic        out_v_rne, out_v_trz;

  always #5 clk = ~clk;

  ftoi #(.ROUND_NEAREST(1)) dut_rne (
    .clk(clk), .rst_n(rst_n), .in_f(in_f), .input_valid(input_valid),
    .out_i(out_i_rne), .out_valid(out_v_rne)
  );

  ftoi #(.ROUND_NEAREST(0)) dut_trz (
    .clk(clk), .rst_n(rst_n), .in_f(in_f), .input_valid(input_valid),
    .out_i(out_i_trz), .out_valid(out_v_trz)
  );

  typedef struct {
    logic [31:0] f;
    logic [31:0] rne;
    logic [31:0] trz;
  } vec_t;

  typedef struct {
    logic [31:0] f;
    logic [31:0] rne;
    logic [31:0] trz;
    int          due;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] tag,
                       input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s in=%h: got %h required %h", name, tag, act, req);
  endtask

  // Reference conversion through double precision; ties are resolved
  // explicitly to even because a real-to-int cast rounds ties away.
  function automatic void model(input logic [31:0] f,
                                output logic [31:0] rne, output logic [31:0] trz);
    logic [7:0]  e;
    logic [10:0] de;
    real         r, d;
    int          t, ri;
    e = f[30:23];
    if (e == 8'd0) begin
      rne = 32'd0; trz = 32'd0;
    end else if (e == 8'd255 && f[22:0] != 23'd0) begin
      rne = 32'h8000_0000; trz = 32'h8000_0000;
    end else if (e >= 8'd158) begin
      rne = f[31] ? 32'h8000_0000 : 32'h7FFF_FFFF; trz = rne;
    end else begin
      de = 11'({3'b0, e} + 11'd896);
      r  = $bitstoreal({f[31], de, f[22:0], 29'b0});
      t  = $rtoi(r);
      d  = r - $itor(t);
      ri = t;
      if (d > 0.5 || (d == 0.5 && t[0])) ri = t + 1;
      else if (d < -0.5 || (d == -0.5 && t[0])) ri = t - 1;
      rne = 32'(ri);
      trz = 32'(t);
    end
  endfunction

  // Drive one operand for a single cycle and queue its expectation
  task automatic send(input logic [31:0] f, input logic [31:0] rne, input logic [31:0] trz);
    exp_t e;
    @(posedge clk);
    #1;
    in_f        = f;
    input_valid = 1'b1;
    e.f = f; e.rne = rne; e.trz = trz; e.due = cyc + 3;
    exp_q.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
      input_valid = 1'b0;
    end
  endtask

  task automatic drain();
    int waited = 0;
    while (exp_q.size() != 0 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    check("drain", 32'd0, 32'(exp_q.size()), 32'd0);
  endtask

  // Result monitor: order, value in both rounding modes, and latency
  always @(negedge clk) begin
    exp_t e;
    if (out_v_rne || out_v_trz) begin
      check("valid_pair", 32'd0, {31'b0, out_v_trz}, {31'b0, out_v_rne});
      if (exp_q.size() == 0) begin
        check("spurious_valid", 32'd0, {31'b0, out_v_rne | out_v_trz}, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("rne", e.f, out_i_rne, e.rne);
        check("trz", e.f, out_i_trz, e.trz);
        check("latency", e.f, 32'(cyc), 32'(e.due));
        $display("txn in=%h rne=%h trz=%h cyc=%0d", e.f, out_i_rne, out_i_trz, cyc);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  vec_t vecs[$];
  int   seen;

  initial begin
    logic [31:0] f, er, et;
    int          s, e;

    rst_n = 1'b0; input_valid = 1'b0; in_f = 32'd0;
    repeat (2) @(negedge clk);
    check("reset_valid", 32'd0, {31'b0, out_v_rne}, 32'd0);
    check("reset_out_i", 32'd0, out_i_rne, 32'd0);
    rst_n = 1'b1;

    vecs = '{
      '{32'h0000_0000, 32'h0000_0000, 32'h0000_0000},
      '{32'h3F80_0000, 32'h0000_0001, 32'h0000_0001},
      '{32'hBF80_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF},
      '{32'h42C8_0000, 32'h0000_0064, 32'h0000_0064},
      '{32'h3F00_0000, 32'h0000_0000, 32'h0000_0000},
      '{32'h3FC0_0000, 32'h0000_0002, 32'h0000_0001},
      '{32'h4020_0000, 32'h0000_0002, 32'h0000_0002},
      '{32'hC020_0000, 32'hFFFF_FFFE, 32'hFFFF_FFFE},
      '{32'h3F40_0000, 32'h0000_0001, 32'h0000_0000},
      '{32'h4060_0000, 32'h0000_0004, 32'h0000_0003},
      '{32'hBFC0_0000, 32'hFFFF_FFFE, 32'hFFFF_FFFF},
      '{32'h3F00_0001, 32'h0000_0001, 32'h0000_0000},
      '{32'h3EFF_FFFF, 32'h0000_0000, 32'h0000_0000},
      '{32'h8000_0000, 32'h0000_0000, 32'h0000_0000},
      '{32'h4F32_D05E, 32'h7FFF_FFFF, 32'h7FFF_FFFF},
      '{32'hCF00_0000, 32'h8000_0000, 32'h8000_0000},
      '{32'h7F80_0000, 32'h7FFF_FFFF, 32'h7FFF_FFFF},
      '{32'hFF80_0000, 32'h8000_0000, 32'h8000_0000},
      '{32'h7FC0_0000, 32'h8000_0000, 32'h8000_0000},
      '{32'hFFC0_0000, 32'h8000_0000, 32'h8000_0000},
      '{32'h0000_0001, 32'h0000_0000, 32'h0000_0000},
      '{32'h4EFF_FFFF, 32'h7FFF_FF80, 32'h7FFF_FF80},
      '{32'h4B80_0001, 32'h0100_0002, 32'h0100_0002}
    };

    // Directed table, one operand every other cycle
    foreach (vecs[i]) begin
      send(vecs[i].f, vecs[i].rne, vecs[i].trz);
      idle(1);
    end
    drain();

    // Back-to-back random stream with input_valid held high
    for (int i = 0; i < 200; i++) begin
      s = $urandom_range(0, 1);
      e = $urandom_range(100, 160);
      f = {s[0], e[7:0], 23'($urandom)};
      model(f, er, et);
      send(f, er, et);
    end
    idle(1);
    drain();

    // Known nonzero result so the async clear of out_i is observable
    send(32'h42C8_0000, 32'h0000_0064, 32'h0000_0064);
    idle(1);
    drain();

    // Reset while three operands are in flight; none may emerge
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      in_f = 32'h3F80_0000;
      input_valid = 1'b1;
    end
    #2;
    input_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("async_clr_valid", 32'd0, {31'b0, out_v_rne}, 32'd0);
    check("async_clr_out_i", 32'd0, out_i_rne, 32'd0);
    check("async_clr_out_i_trz", 32'd0, out_i_trz, 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      seen += int'(out_v_rne) + int'(out_v_trz);
    end
    check("flushed", 32'd0, 32'(seen), 32'd0);

    // First operand after reset returns after the normal latency
    send(32'hC020_0000, 32'hFFFF_FFFE, 32'hFFFF_FFFE);
    idle(1);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
